// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared definitions for the one-hot shift step controller.
//   - state_t           : sequencer FSM states (IDLE, PRESS, HELD, REPEAT, RELEASE)
//   - ST_* constants    : state encodings, kept as plain 3-bit constants so older
//                         blocks and debug tooling can compare against them
//   - DEF_* constants   : default parameter values for shift_step_ctrl
//   - DROP_W / DROP_MAX : dropped-step counter width and saturation value
//   - max3()            : helper used to size the shared timing counter
package shift_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD    = 3'd2;
  localparam logic [2:0] ST_REPEAT  = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    PRESS   = ST_PRESS,
    HELD    = ST_HELD,
    REPEAT  = ST_REPEAT,
    RELEASE = ST_RELEASE
  } state_t;

  localparam int DEF_WIDTH           = 16;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 25_000_000;
  localparam int DEF_REPEAT_CYCLES   = 5_000_000;

  localparam int           DROP_W   = 8;
  localparam logic [7:0]   DROP_MAX = 8'd255;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// btn_sync: two-flop synchronizer for a single asynchronous level.
// Ports:
//   clk      in  : clock
//   clr      in  : synchronous active-high reset, both flops clear to 0
//   async_in in  : raw asynchronous input
//   sync_out out : input retimed into the clk domain (two-cycle latency)
module btn_sync (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (clr) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/shift_step_ctrl.sv
// shift_step_ctrl: push-button sequencer for the one-hot shift datapath.
// A raw button is synchronized and debounced; each debounced press issues one
// step that rotates the one-hot position left (wrapping). Optional auto-repeat
// issues further steps while the button stays held.
//
// Build option: define SHIFT_AUTO_REPEAT_EN to compile in the REPEAT state and
// hold/repeat timing. Without it, exactly one step is issued per press.
//
// Ports:
//   clk        in            : clock, all state on the rising edge
//   clr        in            : synchronous active-high reset, overrides all
//   btn        in            : raw asynchronous push-button
//   pos_ready  in            : downstream accepts the current position
//   pos_onehot out [WIDTH]   : current one-hot position (reset 1)
//   pos_idx    out [log2 W]  : binary index of the set bit
//   pos_valid  out           : current position not yet acknowledged
//   drop_cnt   out [8]       : saturating count of dropped steps
//   busy       out           : FSM is not in IDLE
//   state_dbg  out           : current FSM state, for observation only
//
// Handshake: pos_valid rises with every accepted step and stays high until a
// cycle where pos_valid and pos_ready are both high; that cycle completes the
// transfer and clears pos_valid, unless a new step is accepted in the same
// cycle, in which case pos_valid stays high for the new position. pos_ready
// while pos_valid is low is ignored. A step arriving while pos_valid is high
// and pos_ready is low is dropped and counted in drop_cnt.
//
// WIDTH must be a power of two and >= 2 so pos_idx wraps naturally.
module shift_step_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter int WIDTH           = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     btn,
  input  logic                     pos_ready,
  output logic [WIDTH-1:0]         pos_onehot,
  output logic [$clog2(WIDTH)-1:0] pos_idx,
  output logic                     pos_valid,
  output logic [DROP_W-1:0]        drop_cnt,
  output logic                     busy,
  output state_t                   state_dbg
);

  localparam int IDX_W   = $clog2(WIDTH);
  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam int CNT_RAW = $clog2(CNT_MAX);
  localparam int CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;

  // Terminal counts: a phase lasting N cycles ends when the counter, cleared
  // on entry, has reached N-1.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SHIFT_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             btn_s;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             step;
  logic             accept;
  logic             busy_q;

  btn_sync u_btn_sync (
    .clk      (clk),
    .clr      (clr),
    .async_in (btn),
    .sync_out (btn_s)
  );

  // One counter is shared by all timed phases; every transition clears it so
  // each phase starts counting from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = PRESS;
          cnt_nxt   = '0;
        end
      end
      PRESS: begin
        if (!btn_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          step      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end
`ifdef SHIFT_AUTO_REPEAT_EN
        else if (cnt == HOLD_LAST) begin
          state_nxt = REPEAT;
          cnt_nxt   = '0;
          step      = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
`ifdef SHIFT_AUTO_REPEAT_EN
      REPEAT: begin
        if (!btn_s) begin
          state_nxt = RELEASE;
          cnt_nxt   = '0;
        end else if (cnt == REP_LAST) begin
          cnt_nxt = '0;
          step    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
`endif
      RELEASE: begin
        // A bounce back to pressed re-enters HELD without stepping, so a
        // chattering release cannot generate extra steps.
        if (btn_s) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt != IDLE);
    end
  end

  // A step lands if nothing is outstanding or the outstanding position is
  // being taken this very cycle.
  assign accept = step && (!pos_valid || pos_ready);

  always_ff @(posedge clk) begin
    if (clr) begin
      pos_onehot <= WIDTH'(1);
      pos_idx    <= '0;
      pos_valid  <= 1'b0;
      drop_cnt   <= '0;
    end else if (accept) begin
      pos_onehot <= {pos_onehot[WIDTH-2:0], pos_onehot[WIDTH-1]};
      pos_idx    <= pos_idx + IDX_W'(1);
      pos_valid  <= 1'b1;
    end else begin
      if (step && (drop_cnt != DROP_MAX)) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (pos_valid && pos_ready) begin
        pos_valid <= 1'b0;
      end
    end
  end

  assign busy      = busy_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_shift_step_ctrl.sv
module tb_shift_step_ctrl;
  import shift_ctrl_pkg::*;

  localparam int W    = 16;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  // ---------------- clock / reset / dut ----------------
  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         btn = 1'b0;
  logic         pos_ready = 1'b1;
  logic [W-1:0] pos_onehot;
  logic [3:0]   pos_idx;
  logic         pos_valid;
  logic [7:0]   drop_cnt;
  logic         busy;
  state_t       state_dbg;

  always #5 clk = ~clk;

  shift_step_ctrl #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .clr(clr), .btn(btn), .pos_ready(pos_ready),
    .pos_onehot(pos_onehot), .pos_idx(pos_idx), .pos_valid(pos_valid),
    .drop_cnt(drop_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc = 0;       // number of rising edges so far
  int e0 = 0;        // edge that first samples btn=1 for the current press
  bit chk_en = 1'b0;
  bit rec_en = 1'b0;
  logic [15:0] exp_q[$];   // expected step edges, relative to e0
  logic [3:0]  prev_idx = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phases follow the button's debounced life: idle, debouncing a press,
  // held, auto-repeating, debouncing a release.
  localparam int P_IDLE = 0, P_PRESS = 1, P_HELD = 2, P_REP = 3, P_REL = 4;
`ifdef SHIFT_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  bit m_s1 = 0, m_s2 = 0;
  int m_phase = P_IDLE;
  int m_n = 0;
  int m_idx = 0;
  bit m_valid = 0;
  int m_drop = 0;

  always @(posedge clk) begin
    bit b;
    bit stp;
    cyc++;
    if (clr) begin
      m_s1 = 0; m_s2 = 0; m_phase = P_IDLE; m_n = 0;
      m_idx = 0; m_valid = 0; m_drop = 0;
    end else begin
      b = m_s2;
      m_s2 = m_s1;
      m_s1 = btn;
      stp = 0;
      case (m_phase)
        P_IDLE:  if (b) begin m_phase = P_PRESS; m_n = 0; end
        P_PRESS: begin
          if (!b) m_phase = P_IDLE;
          else begin
            m_n++;
            if (m_n == DEB) begin m_phase = P_HELD; m_n = 0; stp = 1; end
          end
        end
        P_HELD: begin
          if (!b) begin m_phase = P_REL; m_n = 0; end
          else if (AR) begin
            m_n++;
            if (m_n == HOLD) begin m_phase = P_REP; m_n = 0; stp = 1; end
          end
        end
        P_REP: begin
          if (!b) begin m_phase = P_REL; m_n = 0; end
          else begin
            m_n++;
            if (m_n == REP) begin m_n = 0; stp = 1; end
          end
        end
        default: begin
          if (b) begin m_phase = P_HELD; m_n = 0; end
          else begin
            m_n++;
            if (m_n == DEB) begin m_phase = P_IDLE; m_n = 0; end
          end
        end
      endcase
      if (stp) begin
        if (!m_valid || pos_ready) begin
          m_idx = (m_idx + 1) % W;
          m_valid = 1;
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end else if (m_valid && pos_ready) begin
        m_valid = 0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("pos_onehot", 32'(pos_onehot), 32'd1 << m_idx);
      check("pos_idx", 32'(pos_idx), 32'(m_idx));
      check("pos_valid", 32'(pos_valid), 32'(m_valid));
      check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
      check("busy", 32'(busy), 32'(m_phase != P_IDLE));
      if (rec_en && (pos_idx != prev_idx)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step_at", 32'(cyc - e0), 32'hffff_ffff);
        end else begin
          check("step_at", 32'(cyc - e0), 32'(exp_q.pop_front()));
        end
      end
      prev_idx = pos_idx;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge. btn is high for hi rising edges then low for lo.
  // rdy_at >= 0 raises pos_ready only for edge e0+rdy_at.
  task automatic press(input int hi, input int lo, input int rdy_at);
    logic bg;
    bg = pos_ready;
    btn = 1'b1;
    e0 = cyc + 1;
    for (int i = 0; i < hi + lo; i++) begin
      @(negedge clk);
      if (i == hi - 1) btn = 1'b0;
      if (rdy_at >= 0) pos_ready = (cyc == e0 + rdy_at - 1) ? 1'b1 : bg;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    repeat (2) @(negedge clk);
    check("rst_onehot", 32'(pos_onehot), 32'h0001);
    check("rst_idx", 32'(pos_idx), 32'd0);
    check("rst_valid", 32'(pos_valid), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clr = 1'b0;
    chk_en = 1'b1;

    // bounce: never stable long enough
    rec_en = 1'b1;
    for (int k = 0; k < 4; k++) press(3, 1, -1);
    repeat (10) @(negedge clk);
    check("bounce_onehot", 32'(pos_onehot), 32'h0001);

    // clean press: single step at E0+6
    exp_q.push_back(16'd6);
    press(8, 12, -1);
    check("clean_onehot", 32'(pos_onehot), 32'h0002);
    check("clean_steps_left", 32'(exp_q.size()), 32'd0);

    // long hold, covering the listed repeat edges
`ifdef SHIFT_AUTO_REPEAT_EN
    exp_q.push_back(16'd6);  exp_q.push_back(16'd16); exp_q.push_back(16'd19);
    exp_q.push_back(16'd22); exp_q.push_back(16'd25); exp_q.push_back(16'd28);
    press(28, 12, -1);
    check("hold_onehot", 32'(pos_onehot), 32'h0080);
`else
    exp_q.push_back(16'd6);
    press(28, 12, -1);
    check("hold_onehot", 32'(pos_onehot), 32'h0004);
`endif
    check("hold_steps_left", 32'(exp_q.size()), 32'd0);
    rec_en = 1'b0;

    // wrap around after 16 presses
    do_reset();
    for (int k = 0; k < 15; k++) press(8, 12, -1);
    check("wrap15_onehot", 32'(pos_onehot), 32'h8000);
    check("wrap15_idx", 32'(pos_idx), 32'd15);
    press(8, 12, -1);
    check("wrap16_onehot", 32'(pos_onehot), 32'h0001);
    check("wrap16_idx", 32'(pos_idx), 32'd0);

    // backpressure: first step lands, next two drop
    pos_ready = 1'b0;
    for (int k = 0; k < 3; k++) press(8, 12, -1);
    check("bp_onehot", 32'(pos_onehot), 32'h0002);
    check("bp_drop", 32'(drop_cnt), 32'd2);
    check("bp_valid", 32'(pos_valid), 32'd1);
    pos_ready = 1'b1;
    @(negedge clk);
    pos_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_cleared", 32'(pos_valid), 32'd0);
    press(8, 12, -1);
    check("bp_after_onehot", 32'(pos_onehot), 32'h0004);
    // ready pulse coincides with the step edge: step accepted
    press(8, 12, 6);
    check("coincide_onehot", 32'(pos_onehot), 32'h0008);
    check("coincide_drop", 32'(drop_cnt), 32'd2);
    check("coincide_valid", 32'(pos_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
